// File: rtl/audio_pkg.sv
// Shared audio definitions: sequencer states, sample width, ROM end-marker encoding
// and default tone constants.
package audio_pkg;

    localparam int SAMPLE_W            = 32;
    localparam int DEFAULT_AMPLITUDE   = 100_000_000;
    localparam int DEFAULT_BEAT_CYCLES = 2_500_000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // The end marker is the all-ones ROM word, whatever the ROM word width is.
    function automatic logic is_end_marker(input logic [31:0] q, input int width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (q & mask) == mask;
    endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// Sample handshake between the tone sequencer and the Audio_Controller DAC FIFO.
interface tone_sequencer_if;
    import audio_pkg::*;

    logic                       audio_out_allowed;
    logic                       write_audio_out;
    logic signed [SAMPLE_W-1:0] left_out;
    logic signed [SAMPLE_W-1:0] right_out;

    modport master (
        input  audio_out_allowed,
        output write_audio_out,
        output left_out,
        output right_out
    );

    modport slave (
        output audio_out_allowed,
        input  write_audio_out,
        input  left_out,
        input  right_out
    );

endinterface

// File: rtl/tone_sequencer_square_osc.sv
// Square-wave oscillator: half-period counter and phase; the registered sample always
// describes the cycle that follows the edge it was written on.
module square_osc
    import audio_pkg::*;
#(
    parameter int PERIOD_W  = 19,
    parameter int AMPLITUDE = DEFAULT_AMPLITUDE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PERIOD_W-1:0]        period,
    input  logic                       clear,
    input  logic                       enable,
    output logic signed [SAMPLE_W-1:0] sample
);

    localparam logic signed [SAMPLE_W-1:0] AMP_POS = SAMPLE_W'(AMPLITUDE);
    localparam logic signed [SAMPLE_W-1:0] AMP_NEG = -AMP_POS;

    logic [PERIOD_W-1:0] half_cnt;
    logic                phase;
    logic                rest;
    logic                wrap;

    assign rest = (period == '0);
    assign wrap = !rest && (half_cnt == period - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_cnt <= '0;
            phase    <= 1'b0;
            sample   <= '0;
        end else if (clear) begin
            // A new note always starts on the negative half.
            half_cnt <= '0;
            phase    <= 1'b0;
            sample   <= rest ? '0 : AMP_NEG;
        end else if (enable && !rest) begin
            if (wrap) begin
                half_cnt <= '0;
                phase    <= ~phase;
                sample   <= phase ? AMP_NEG : AMP_POS;
            end else begin
                half_cnt <= half_cnt + 1'b1;
                sample   <= phase ? AMP_POS : AMP_NEG;
            end
        end else begin
            sample <= '0;
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// Note-ROM driven square-wave jingle source feeding Audio_Controller; FSM, beat timing
// and ROM addressing live here, waveform generation in square_osc.
module tone_sequencer
    import audio_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int LAST_ADDR   = 999,
    parameter int PERIOD_W    = 19,
    parameter int BEAT_CYCLES = DEFAULT_BEAT_CYCLES,
    parameter int AMPLITUDE   = DEFAULT_AMPLITUDE,
    parameter int ROM_LATENCY = 1
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic                play,
    input  logic                loop,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [PERIOD_W-1:0] rom_q,
    tone_sequencer_if.master    aud,
    output logic                busy,
    output logic                done
);

    localparam int FETCH_W = $clog2(ROM_LATENCY + 1) + 1;
    localparam int BEAT_W  = $clog2(BEAT_CYCLES);

    localparam logic [FETCH_W-1:0] FETCH_LAST = FETCH_W'(ROM_LATENCY);
    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(LAST_ADDR);

    seq_state_t          state, state_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [FETCH_W-1:0]  fetch_cnt, fetch_n;
    logic [BEAT_W-1:0]   beat_cnt, beat_n;
    logic [PERIOD_W-1:0] period_q, period_n;
    logic                osc_clear, osc_enable;
    logic signed [SAMPLE_W-1:0] sample;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rom_addr  <= '0;
            fetch_cnt <= '0;
            beat_cnt  <= '0;
            period_q  <= '0;
        end else begin
            state     <= state_n;
            rom_addr  <= addr_n;
            fetch_cnt <= fetch_n;
            beat_cnt  <= beat_n;
            period_q  <= period_n;
        end
    end

    always_comb begin
        state_n    = state;
        addr_n     = rom_addr;
        fetch_n    = '0;
        beat_n     = beat_cnt;
        period_n   = period_q;
        osc_clear  = 1'b0;
        osc_enable = 1'b0;
        unique case (state)
            IDLE: begin
                addr_n = '0;
                if (play) begin
                    state_n = FETCH;
                    beat_n  = '0;
                end
            end
            FETCH: begin
                if (!play) begin
                    state_n = IDLE;
                    addr_n  = '0;
                end else if (fetch_cnt == FETCH_LAST) begin
                    period_n = rom_q;
                    if (is_end_marker(32'(rom_q), PERIOD_W)) begin
                        state_n = DONE;
                        addr_n  = '0;
                    end else begin
                        state_n   = PLAY;
                        osc_clear = 1'b1;
                    end
                end else begin
                    fetch_n = fetch_cnt + 1'b1;
                end
            end
            PLAY: begin
                if (!play) begin
                    state_n = IDLE;
                    addr_n  = '0;
                end else if (beat_cnt == BEAT_LAST) begin
                    beat_n = '0;
                    if (rom_addr < ADDR_LAST) begin
                        state_n = FETCH;
                        addr_n  = rom_addr + 1'b1;
                    end else if (loop) begin
                        state_n = FETCH;
                        addr_n  = '0;
                    end else begin
                        state_n = DONE;
                        addr_n  = '0;
                    end
                end else begin
                    beat_n     = beat_cnt + 1'b1;
                    osc_enable = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                addr_n  = '0;
            end
            default: begin
                state_n = IDLE;
                addr_n  = '0;
            end
        endcase
    end

    // On the latching edge the oscillator must see the freshly fetched period.
    square_osc #(
        .PERIOD_W  (PERIOD_W),
        .AMPLITUDE (AMPLITUDE)
    ) u_osc (
        .clk    (CLOCK_50),
        .rst_n  (reset_n),
        .period (osc_clear ? rom_q : period_q),
        .clear  (osc_clear),
        .enable (osc_enable),
        .sample (sample)
    );

    assign aud.write_audio_out = (state == PLAY) && aud.audio_out_allowed;
    assign aud.left_out        = sample;
    assign aud.right_out       = sample;
    assign busy                = (state != IDLE);
    assign done                = (state == DONE);

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: a behavioural ROM and a cycle trace derived
// from the note list, compared every cycle against the DUT.
module tb_tone_sequencer;

    localparam int ADDR_W    = 10;
    localparam int LAST_ADDR = 3;
    localparam int PERIOD_W  = 19;
    localparam int BEAT      = 16;
    localparam int AMP       = 100;
    localparam int ROM_LAT   = 1;
    localparam logic [PERIOD_W-1:0] ALL1 = '1;

    logic                CLOCK_50 = 1'b0;
    logic                reset_n  = 1'b0;
    logic                play     = 1'b0;
    logic                loop     = 1'b0;
    logic [ADDR_W-1:0]   rom_addr;
    logic [PERIOD_W-1:0] rom_q;
    logic                busy;
    logic                done;
    logic [PERIOD_W-1:0] rom [0:3];

    tone_sequencer_if aud ();

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) rom_q <= rom[rom_addr[1:0]];

    tone_sequencer #(
        .ADDR_W      (ADDR_W),
        .LAST_ADDR   (LAST_ADDR),
        .PERIOD_W    (PERIOD_W),
        .BEAT_CYCLES (BEAT),
        .AMPLITUDE   (AMP),
        .ROM_LATENCY (ROM_LAT)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .play     (play),
        .loop     (loop),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .aud      (aud.master),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        logic busy;
        logic playing;
        logic done;
        int   addr;
        int   sample;
    } exp_t;

    exp_t trace[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Square wave from first principles: k-th cycle of a note with half-period p.
    function automatic int model_sample(input int p, input int k);
        if (p == 0) return 0;
        return ((k / p) % 2 == 0) ? -AMP : AMP;
    endfunction

    function automatic exp_t mk(input logic b, input logic pl, input logic d,
                                input int a, input int s);
        exp_t e;
        e.busy = b; e.playing = pl; e.done = d; e.addr = a; e.sample = s;
        return e;
    endfunction

    // Expected cycles from the first FETCH cycle onwards; stops after DONE or max_beats.
    task automatic build(input bit lp, input int max_beats);
        int a, beats;
        logic [PERIOD_W-1:0] p;
        trace.delete();
        a = 0;
        beats = 0;
        for (int guard = 0; guard < 64; guard++) begin
            for (int f = 0; f < ROM_LAT + 1; f++) trace.push_back(mk(1, 0, 0, a, 0));
            p = rom[a];
            if (p == ALL1) begin
                trace.push_back(mk(1, 0, 1, 0, 0));
                return;
            end
            for (int k = 0; k < BEAT; k++)
                trace.push_back(mk(1, 1, 0, a, model_sample(int'(p), k)));
            beats++;
            if (a < LAST_ADDR) a++;
            else if (lp) a = 0;
            else begin
                trace.push_back(mk(1, 0, 1, 0, 0));
                return;
            end
            if (beats >= max_beats) return;
        end
    endtask

    task automatic start(input bit lp);
        @(negedge CLOCK_50);
        loop = lp;
        play = 1'b1;
    endtask

    // mode 0: allowed held high, 1: alternating, 2: random. n<0 checks the whole trace.
    task automatic run_trace(input string name, input int mode, input int n);
        int   len;
        logic alw;
        exp_t e;
        len = (n < 0 || n > trace.size()) ? trace.size() : n;
        for (int i = 0; i < len; i++) begin
            @(negedge CLOCK_50);
            case (mode)
                0:       alw = 1'b1;
                1:       alw = i[0];
                default: alw = 1'($urandom);
            endcase
            aud.audio_out_allowed = alw;
            #1;
            e = trace[i];
            check($sformatf("%s busy c%0d", name, i), busy, e.busy);
            check($sformatf("%s done c%0d", name, i), done, e.done);
            check($sformatf("%s addr c%0d", name, i), rom_addr, e.addr);
            check($sformatf("%s left c%0d", name, i), aud.left_out, e.sample);
            check($sformatf("%s right c%0d", name, i), aud.right_out, e.sample);
            check($sformatf("%s write c%0d", name, i), aud.write_audio_out, e.playing & alw);
        end
    endtask

    task automatic stop_and_check_idle(input string name);
        play = 1'b0;
        aud.audio_out_allowed = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLOCK_50);
            #1;
            check($sformatf("%s idle busy %0d", name, i), busy, 1'b0);
            check($sformatf("%s idle done %0d", name, i), done, 1'b0);
            check($sformatf("%s idle addr %0d", name, i), rom_addr, 0);
            check($sformatf("%s idle left %0d", name, i), aud.left_out, 0);
            check($sformatf("%s idle write %0d", name, i), aud.write_audio_out, 1'b0);
        end
    endtask

    initial begin
        aud.audio_out_allowed = 1'b1;
        for (int i = 0; i < 4; i++) rom[i] = 19'd4;
        #3;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset addr", rom_addr, 0);
        check("reset left", aud.left_out, 0);
        check("reset right", aud.right_out, 0);
        check("reset write", aud.write_audio_out, 1'b0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;

        // Plain sequence, natural end.
        build(0, 99);
        start(0);
        run_trace("seq4", 0, -1);
        stop_and_check_idle("seq4");

        // Rest note and differing periods.
        rom[0] = 19'd2; rom[1] = 19'd0; rom[2] = 19'd3; rom[3] = 19'd2;
        build(0, 99);
        start(0);
        run_trace("rest", 0, -1);
        stop_and_check_idle("rest");

        // End marker in entry 1.
        rom[0] = 19'd5; rom[1] = ALL1; rom[2] = 19'd5; rom[3] = 19'd5;
        build(0, 99);
        start(0);
        run_trace("endmk", 0, -1);
        stop_and_check_idle("endmk");

        // Looping, then abort on the final cycle of a beat (abort beats beat-end).
        for (int i = 0; i < 4; i++) rom[i] = 19'd4;
        build(1, 6);
        start(1);
        run_trace("loop", 0, -1);
        stop_and_check_idle("loop");

        // FIFO back-pressure alternating every cycle.
        rom[0] = 19'd3; rom[1] = 19'd1; rom[2] = 19'd6; rom[3] = 19'd2;
        build(0, 99);
        start(0);
        run_trace("alt", 1, -1);
        stop_and_check_idle("alt");

        // Random notes and random back-pressure.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) rom[i] = 19'($urandom_range(0, 7));
            build(0, 99);
            start(0);
            run_trace($sformatf("rnd%0d", r), 2, -1);
            stop_and_check_idle($sformatf("rnd%0d", r));
        end

        // Abort in the middle of beat 2.
        for (int i = 0; i < 4; i++) rom[i] = 19'($urandom_range(1, 5));
        build(0, 99);
        start(0);
        run_trace("abort", 2, 2 * (BEAT + ROM_LAT + 1) + ROM_LAT + 1 + BEAT / 2);
        stop_and_check_idle("abort");

        // Asynchronous reset mid-PLAY.
        for (int i = 0; i < 4; i++) rom[i] = 19'd4;
        build(0, 99);
        start(0);
        run_trace("arst", 0, ROM_LAT + 1 + 6);
        #4;
        reset_n = 1'b0;
        #1;
        check("arst busy", busy, 1'b0);
        check("arst addr", rom_addr, 0);
        check("arst left", aud.left_out, 0);
        check("arst right", aud.right_out, 0);
        check("arst write", aud.write_audio_out, 1'b0);
        check("arst done", done, 1'b0);
        @(negedge CLOCK_50);
        play = 1'b0;
        reset_n = 1'b1;
        stop_and_check_idle("arst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
